// File: rtl/uart_scan_loader_pkg.sv
// Shared definitions for the UART scan loader: parser states and protocol bytes.
package uart_scan_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPayload,
        StShift,
        StUpdate,
        StResp
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] STAT_ACK  = 8'h06;
    localparam logic [7:0] STAT_NAK  = 8'h15;

endpackage

// File: rtl/uart_scan_loader_scan_shifter.sv
// Serialises a flat payload into the scan chain with a divided scan clock,
// then holds the update strobe for one scan phase and pulses done.
module scan_shifter #(
    parameter int unsigned SCAN_BYTES = 16,
    parameter int unsigned SCAN_DIV   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [SCAN_BYTES*8-1:0] payload,
    output logic                    scan_clk,
    output logic                    scan_en,
    output logic                    scan_in,
    output logic                    scan_update,
    output logic                    done
);

    localparam int unsigned NBITS = SCAN_BYTES * 8;
    localparam int unsigned BW    = $clog2(NBITS);
    // A divide of 1 would give a zero-width counter; keep one bit that stays at 0.
    localparam int unsigned PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [BW-1:0] LAST_BIT   = BW'(NBITS - 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(SCAN_DIV - 1);

    logic [NBITS-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [PW-1:0]    phase;

    // Done coincides with the final cycle of the update strobe.
    always_comb begin
        done = scan_update && (phase == LAST_PHASE);
    end

    // Shift and update sequencing; shreg holds the bits still to be driven.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            phase       <= '0;
            scan_clk    <= 1'b0;
            scan_en     <= 1'b0;
            scan_in     <= 1'b0;
            scan_update <= 1'b0;
        end else if (start) begin
            scan_in     <= payload[0];
            shreg       <= payload >> 1;
            bit_cnt     <= '0;
            phase       <= '0;
            scan_clk    <= 1'b0;
            scan_en     <= 1'b1;
            scan_update <= 1'b0;
        end else if (scan_en) begin
            if (phase == LAST_PHASE) begin
                phase <= '0;
                if (!scan_clk) begin
                    scan_clk <= 1'b1;
                end else if (bit_cnt == LAST_BIT) begin
                    scan_clk    <= 1'b0;
                    scan_en     <= 1'b0;
                    scan_in     <= 1'b0;
                    scan_update <= 1'b1;
                end else begin
                    scan_clk <= 1'b0;
                    bit_cnt  <= bit_cnt + 1'b1;
                    scan_in  <= shreg[0];
                    shreg    <= shreg >> 1;
                end
            end else begin
                phase <= phase + 1'b1;
            end
        end else if (scan_update) begin
            if (phase == LAST_PHASE) begin
                phase       <= '0;
                scan_update <= 1'b0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_scan_loader.sv
// Host command parser: collects a 'W' packet, drives the scan shifter and
// returns ACK/NAK to the UART transmitter.
module uart_scan_loader
    import uart_scan_loader_pkg::*;
#(
    parameter int unsigned SCAN_BYTES     = 16,
    parameter int unsigned SCAN_DIV       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_250_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       scan_clk,
    output logic       scan_en,
    output logic       scan_in,
    output logic       scan_update,
    output logic       busy
);

    localparam int unsigned NBITS = SCAN_BYTES * 8;
    localparam int unsigned BCW   = $clog2(SCAN_BYTES + 1);
    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BCW-1:0] LAST_BYTE   = BCW'(SCAN_BYTES - 1);
    localparam logic [TW-1:0]  TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    state_t           state;
    logic [BCW-1:0]   byte_cnt;
    logic [TW-1:0]    timeout_cnt;
    logic [NBITS-1:0] payload;
    logic [NBITS-1:0] payload_next;
    logic             rx_fire;
    logic             last_byte;
    logic             shift_start;
    logic             shift_done;

    // The shifter loads the buffer including the byte arriving this cycle.
    always_comb begin
        rx_fire      = rx_valid && rx_ready;
        last_byte    = (byte_cnt == LAST_BYTE);
        shift_start  = (state == StPayload) && rx_fire && last_byte;
        payload_next = payload;
        payload_next[byte_cnt*8 +: 8] = rx_data;
    end

    // Parser FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= StIdle;
            byte_cnt    <= '0;
            timeout_cnt <= '0;
            payload     <= '0;
            rx_ready    <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (rx_fire && rx_data == CMD_WRITE) begin
                        state       <= StPayload;
                        byte_cnt    <= '0;
                        timeout_cnt <= '0;
                        busy        <= 1'b1;
                        rx_ready    <= 1'b1;
                    end else if (rx_fire) begin
                        state    <= StResp;
                        tx_valid <= 1'b1;
                        tx_data  <= STAT_NAK;
                        busy     <= 1'b1;
                        rx_ready <= 1'b0;
                    end else begin
                        rx_ready <= 1'b1;
                    end
                end
                StPayload: begin
                    // An accepted byte takes priority over an expiring timeout.
                    if (rx_fire) begin
                        payload     <= payload_next;
                        timeout_cnt <= '0;
                        if (last_byte) begin
                            state    <= StShift;
                            rx_ready <= 1'b0;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (timeout_cnt == TIMEOUT_MAX) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                StShift: begin
                    // With a divide of 1 done arrives before UPDATE is ever entered.
                    if (shift_done) begin
                        state    <= StResp;
                        tx_valid <= 1'b1;
                        tx_data  <= STAT_ACK;
                    end else if (scan_update) begin
                        state <= StUpdate;
                    end
                end
                StUpdate: begin
                    if (shift_done) begin
                        state    <= StResp;
                        tx_valid <= 1'b1;
                        tx_data  <= STAT_ACK;
                    end
                end
                StResp: begin
                    if (tx_ready) begin
                        state    <= StIdle;
                        tx_valid <= 1'b0;
                        rx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    scan_shifter #(
        .SCAN_BYTES (SCAN_BYTES),
        .SCAN_DIV   (SCAN_DIV)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .start       (shift_start),
        .payload     (payload_next),
        .scan_clk    (scan_clk),
        .scan_en     (scan_en),
        .scan_in     (scan_in),
        .scan_update (scan_update),
        .done        (shift_done)
    );

endmodule

// File: tb/tb_uart_scan_loader.sv
// Self-checking bench for uart_scan_loader with SCAN_BYTES=2, SCAN_DIV=2.
module tb_uart_scan_loader;
    import uart_scan_loader_pkg::*;

    localparam int SB        = 2;
    localparam int DIV       = 2;
    localparam int TO        = 100;
    localparam int SHIFT_CYC = SB * 16 * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       scan_clk, scan_en, scan_in, scan_update, busy;

    uart_scan_loader #(
        .SCAN_BYTES     (SB),
        .SCAN_DIV       (DIV),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .scan_clk    (scan_clk),
        .scan_en     (scan_en),
        .scan_in     (scan_in),
        .scan_update (scan_update),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    // Free-running monitor; tests take baselines instead of clearing it.
    bit         scan_q[$];
    int         en_tot = 0, upd_tot = 0, tog_tot = 0, tx_tot = 0, rx_tot = 0;
    int         en_last = 0, upd_rise = 0;
    logic [7:0] tx_last = 8'h00;
    logic       prev_sclk = 1'b0, prev_upd = 1'b0;

    always @(negedge clk) begin
        if (scan_clk && !prev_sclk) scan_q.push_back(scan_in);
        if (scan_clk != prev_sclk) tog_tot++;
        prev_sclk = scan_clk;
        if (scan_en) begin
            en_tot++;
            en_last = cyc;
        end
        if (scan_update) begin
            upd_tot++;
            if (!prev_upd) upd_rise = cyc;
        end
        prev_upd = scan_update;
        if (tx_valid && tx_ready) begin
            tx_tot++;
            tx_last = tx_data;
        end
        if (rx_valid && rx_ready) rx_tot++;
    end

    int base_q, base_en, base_upd, base_tog, base_tx, base_rx;

    task automatic start_mon();
        base_q   = scan_q.size();
        base_en  = en_tot;
        base_upd = upd_tot;
        base_tog = tog_tot;
        base_tx  = tx_tot;
        base_rx  = rx_tot;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one byte and returns the cycle count just after it was taken.
    task automatic send_byte(input logic [7:0] b, output int c);
        bit taken = 1'b0;
        int waited = 0;
        c = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!taken && waited < 400) begin
            if (rx_ready) begin
                tick();
                c = cyc;
                taken = 1'b1;
            end else begin
                tick();
                waited++;
            end
        end
        rx_valid = 1'b0;
        if (!taken) check("rx accept timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rx_ready"}, rx_ready, 0);
        check({tag, " tx_valid"}, tx_valid, 0);
        check({tag, " tx_data"}, tx_data, 0);
        check({tag, " scan_clk"}, scan_clk, 0);
        check({tag, " scan_en"}, scan_en, 0);
        check({tag, " scan_in"}, scan_in, 0);
        check({tag, " scan_update"}, scan_update, 0);
        check({tag, " busy"}, busy, 0);
    endtask

    // Waits for the status byte, holds off tx_ready, then checks the whole
    // transaction against the reference expectations.
    task automatic finish_pkt(input logic [7:0] exp_stat, input logic [7:0] p0,
                              input logic [7:0] p1, input int last_acc, input int hold);
        bit         seen = 1'b0;
        int         waited = 0;
        bit         exp_ack = (exp_stat == STAT_ACK);
        bit         expq[$];
        logic [7:0] pl[SB];
        while (!seen && waited < 400) begin
            if (tx_valid) seen = 1'b1;
            else begin
                tick();
                waited++;
            end
        end
        if (!seen) begin
            check("tx_valid timeout", 0, 1);
            return;
        end
        check("response latency", cyc - last_acc + 1, exp_ack ? SHIFT_CYC + DIV + 1 : 1);
        for (int i = 0; i < hold; i++) begin
            check("resp tx_valid held", tx_valid, 1);
            check("resp tx_data held", tx_data, exp_stat);
            check("resp rx_ready low", rx_ready, 0);
            tick();
        end
        check("status byte", tx_data, exp_stat);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("post-handshake tx_valid", tx_valid, 0);
        check("post-handshake busy", busy, 0);
        check("post-handshake rx_ready", rx_ready, 1);
        check("bytes sent", tx_tot - base_tx, 1);
        check("sent byte", tx_last, exp_stat);
        if (exp_ack) begin
            pl[0] = p0;
            pl[1] = p1;
            for (int k = 0; k < SB; k++)
                for (int b = 0; b < 8; b++) expq.push_back(pl[k][b]);
            check("scan bit count", scan_q.size() - base_q, SB * 8);
            for (int i = 0; i < SB * 8; i++)
                if (base_q + i < scan_q.size())
                    check($sformatf("scan bit %0d", i), scan_q[base_q + i], expq[i]);
            check("scan_en cycles", en_tot - base_en, SHIFT_CYC);
            check("scan_update cycles", upd_tot - base_upd, DIV);
            check("update follows scan_en", upd_rise - en_last, 1);
        end else begin
            check("no scan_clk activity", tog_tot - base_tog, 0);
            check("no scan_en", en_tot - base_en, 0);
        end
    endtask

    task automatic run_packet(input logic [7:0] cmd, input logic [7:0] p0, input logic [7:0] p1,
                              input int gap, input int hold, input logic [7:0] exp_stat);
        int c;
        start_mon();
        send_byte(cmd, c);
        if (cmd == CMD_WRITE) begin
            send_byte(p0, c);
            repeat (gap) tick();
            send_byte(p1, c);
        end
        finish_pkt(exp_stat, p0, p1, c, hold);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] p0;
        logic [7:0] p1;
        int         gap;
        int         hold;
        logic [7:0] exp_stat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int         c;
        logic [7:0] cmd, p0, p1;

        tbl[0] = '{cmd: 8'h57, p0: 8'hA5, p1: 8'h3C, gap: 0, hold: 0, exp_stat: 8'h06};
        tbl[1] = '{cmd: 8'h41, p0: 8'h00, p1: 8'h00, gap: 0, hold: 0, exp_stat: 8'h15};
        tbl[2] = '{cmd: 8'h57, p0: 8'hFF, p1: 8'h00, gap: 3, hold: 10, exp_stat: 8'h06};
        tbl[3] = '{cmd: 8'h00, p0: 8'h00, p1: 8'h00, gap: 0, hold: 2, exp_stat: 8'h15};
        tbl[4] = '{cmd: 8'h57, p0: 8'h01, p1: 8'h80, gap: 1, hold: 1, exp_stat: 8'h06};
        tbl[5] = '{cmd: 8'h56, p0: 8'h00, p1: 8'h00, gap: 0, hold: 10, exp_stat: 8'h15};

        // Reset state, held over two edges.
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();
        check("rx_ready after reset", rx_ready, 1);
        check("busy after reset", busy, 0);

        foreach (tbl[i]) run_packet(tbl[i].cmd, tbl[i].p0, tbl[i].p1, tbl[i].gap, tbl[i].hold,
                                    tbl[i].exp_stat);

        // Timeout abort: stalled payload returns to IDLE silently.
        start_mon();
        send_byte(CMD_WRITE, c);
        send_byte(8'hA5, c);
        repeat (TO + 2) tick();
        check("timeout busy", busy, 0);
        check("timeout rx_ready", rx_ready, 1);
        check("timeout tx_valid", tx_valid, 0);
        check("timeout no bytes sent", tx_tot - base_tx, 0);
        check("timeout no scan", tog_tot - base_tog, 0);
        // A byte arriving on the cycle the counter reaches its limit still counts.
        run_packet(CMD_WRITE, 8'h01, 8'h02, TO, 0, STAT_ACK);

        // Reset in the middle of SHIFT.
        start_mon();
        send_byte(CMD_WRITE, c);
        send_byte(8'h12, c);
        send_byte(8'h34, c);
        repeat (20) tick();
        check("mid-shift scan_en", scan_en, 1);
        reset = 1'b0;
        tick();
        check_reset_outputs("mid-shift reset");
        reset = 1'b1;
        tick();
        check("aborted packet sent nothing", tx_tot - base_tx, 0);
        run_packet(CMD_WRITE, 8'hA5, 8'h3C, 0, 0, STAT_ACK);

        // A command byte offered during SHIFT waits until RESP completes.
        start_mon();
        send_byte(CMD_WRITE, c);
        send_byte(8'hC3, c);
        send_byte(8'h5A, c);
        rx_data  = CMD_WRITE;
        rx_valid = 1'b1;
        finish_pkt(STAT_ACK, 8'hC3, 8'h5A, c, 3);
        check("held byte not taken", rx_tot - base_rx, 3);
        tick();
        rx_valid = 1'b0;
        check("held byte taken", rx_tot - base_rx, 4);
        check("held byte started packet", busy, 1);
        start_mon();
        send_byte(8'h0F, c);
        send_byte(8'hF0, c);
        finish_pkt(STAT_ACK, 8'h0F, 8'hF0, c, 0);

        // Randomised packets against the reference rules.
        for (int n = 0; n < 20; n++) begin
            cmd = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : CMD_WRITE;
            p0  = 8'($urandom_range(0, 255));
            p1  = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) tick();
            run_packet(cmd, p0, p1, $urandom_range(0, 6), $urandom_range(0, 4),
                       (cmd == CMD_WRITE) ? STAT_ACK : STAT_NAK);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
